// File: rtl/cmos_capture_sequencer.sv
// Captures RGB565 frames from an OV7670-style camera port and writes them to VRAM as
// RGB444 pixels with a linear address. Every camera pin is resynchronized into clk_i.
module cmos_capture_sequencer #(
    parameter int H_PIXELS   = 320,
    parameter int V_LINES    = 240,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  continuous_i,
    input  logic                  pclk_cmos_i,
    input  logic                  vsync_cmos_i,
    input  logic                  href_cmos_i,
    input  logic [7:0]            pixel_data_cmos_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_address_o,
    output logic [11:0]           wr_data_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  error_o
);

    localparam int COL_W  = ($clog2(H_PIXELS + 2) > 9) ? $clog2(H_PIXELS + 2) : 9;
    localparam int LINE_W = ($clog2(V_LINES + 2) > 8) ? $clog2(V_LINES + 2) : 8;
    localparam logic [COL_W-1:0]  H_MAX = COL_W'(H_PIXELS);
    localparam logic [LINE_W-1:0] V_MAX = LINE_W'(V_LINES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_CAPTURE
    } state_e;

    state_e state_q, state_d;

    logic       pclkS1_q, pclkS2_q, pclkS3_q;
    logic       vsyncS1_q, vsyncS2_q, vsyncS3_q;
    logic       hrefS1_q, hrefS2_q, hrefS3_q;
    logic [7:0] dataS1_q, dataS2_q;

    logic                  pclkRise, vsyncRise, vsyncFall, hrefFall;

    logic [COL_W-1:0]      col_q, col_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  phase_q, phase_d;
    logic [6:0]            hiBits_q, hiBits_d;
    logic                  wrEn_q, wrEn_d;
    logic [ADDR_WIDTH-1:0] wrAddr_q, wrAddr_d;
    logic [11:0]           wrData_q, wrData_d;
    logic                  busy_q, busy_d;
    logic                  frameDone_q, frameDone_d;
    logic                  error_q, error_d;

    // Two flops for metastability, a third on the control lines for edge detection.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pclkS1_q  <= 1'b0;
            pclkS2_q  <= 1'b0;
            pclkS3_q  <= 1'b0;
            vsyncS1_q <= 1'b0;
            vsyncS2_q <= 1'b0;
            vsyncS3_q <= 1'b0;
            hrefS1_q  <= 1'b0;
            hrefS2_q  <= 1'b0;
            hrefS3_q  <= 1'b0;
            dataS1_q  <= 8'h00;
            dataS2_q  <= 8'h00;
        end else begin
            pclkS1_q  <= pclk_cmos_i;
            pclkS2_q  <= pclkS1_q;
            pclkS3_q  <= pclkS2_q;
            vsyncS1_q <= vsync_cmos_i;
            vsyncS2_q <= vsyncS1_q;
            vsyncS3_q <= vsyncS2_q;
            hrefS1_q  <= href_cmos_i;
            hrefS2_q  <= hrefS1_q;
            hrefS3_q  <= hrefS2_q;
            dataS1_q  <= pixel_data_cmos_i;
            dataS2_q  <= dataS1_q;
        end
    end

    assign pclkRise  = pclkS2_q & ~pclkS3_q;
    assign vsyncRise = vsyncS2_q & ~vsyncS3_q;
    assign vsyncFall = ~vsyncS2_q & vsyncS3_q;
    assign hrefFall  = ~hrefS2_q & hrefS3_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (vsyncFall) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (vsyncRise) begin
                    state_d = continuous_i ? ST_WAIT_FRAME : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Event priority inside CAPTURE: frame end, frame restart, line end, then byte.
    always_comb begin
        col_d       = col_q;
        line_d      = line_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        hiBits_d    = hiBits_q;
        wrEn_d      = 1'b0;
        wrAddr_d    = wrAddr_q;
        wrData_d    = wrData_q;
        busy_d      = (state_q != ST_IDLE);
        frameDone_d = 1'b0;
        error_d     = error_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    error_d = 1'b0;
                end
            end
            ST_WAIT_FRAME: begin
                if (vsyncFall) begin
                    col_d    = '0;
                    line_d   = '0;
                    addr_d   = '0;
                    phase_d  = 1'b0;
                    wrAddr_d = '0;
                end
            end
            ST_CAPTURE: begin
                if (vsyncRise) begin
                    if (line_q != V_MAX) begin
                        error_d = 1'b1;
                    end
                    frameDone_d = 1'b1;
                end else if (vsyncFall) begin
                    col_d    = '0;
                    line_d   = '0;
                    addr_d   = '0;
                    phase_d  = 1'b0;
                    wrAddr_d = '0;
                    error_d  = 1'b1;
                end else if (hrefFall) begin
                    if (col_q != H_MAX) begin
                        error_d = 1'b1;
                    end
                    if (line_q != '1) begin
                        line_d = line_q + 1'b1;
                    end
                    col_d   = '0;
                    phase_d = 1'b0;
                end else if (pclkRise && hrefS2_q) begin
                    if (!phase_q) begin
                        hiBits_d = {dataS2_q[7:4], dataS2_q[2:0]};
                        phase_d  = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (col_q != '1) begin
                            col_d = col_q + 1'b1;
                        end
                        // Out-of-window pixels are dropped so the address never wraps.
                        if ((col_q < H_MAX) && (line_q < V_MAX)) begin
                            wrEn_d   = 1'b1;
                            wrAddr_d = addr_q;
                            wrData_d = {hiBits_q, dataS2_q[7], dataS2_q[4:1]};
                            addr_d   = addr_q + 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            col_q       <= '0;
            line_q      <= '0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            hiBits_q    <= '0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            col_q       <= col_d;
            line_q      <= line_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            hiBits_q    <= hiBits_d;
            wrEn_q      <= wrEn_d;
            wrAddr_q    <= wrAddr_d;
            wrData_q    <= wrData_d;
            busy_q      <= busy_d;
            frameDone_q <= frameDone_d;
            error_q     <= error_d;
        end
    end

    assign wr_en_o      = wrEn_q;
    assign wr_address_o = wrAddr_q;
    assign wr_data_o    = wrData_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frameDone_q;
    assign error_o      = error_q;

endmodule

// File: doc/cmos_capture_sequencer.md
# cmos_capture_sequencer

Captures frames from the OV7670-style CMOS port into VRAM. It synchronizes the camera's pclk/vsync/href/data into the system clock and waits for a frame boundary. It assembles RGB565 byte pairs into 12-bit RGB444 pixels and issues one VRAM write per pixel, with a linear frame address. It sits between the camera pins and the VRAM write port, and supports single-shot or continuous capture.

## Interface
- H_PIXELS, 320, pixels per line written to VRAM
- V_LINES, 240, lines per frame written to VRAM
- ADDR_WIDTH, 17, VRAM address width (must satisfy 2^ADDR_WIDTH >= H_PIXELS*V_LINES)

Ports:
- clk_i  input  1  system clock; all logic on rising edge
- reset_i  input  1  asynchronous, active-high reset
- start_i  input  1  arm capture (one-cycle pulse, level also accepted)
- continuous_i  input  1  1 = re-arm automatically after each frame
- pclk_cmos_i  input  1  camera pixel clock, asynchronous, sampled as data
- vsync_cmos_i  input  1  camera vsync, high during vertical blanking
- href_cmos_i  input  1  camera line-valid
- pixel_data_cmos_i  input  8  camera byte bus
- wr_en_o  output  1  VRAM write strobe, one cycle per pixel
- wr_address_o  output  ADDR_WIDTH  VRAM write address
- wr_data_o  output  12  pixel {R[3:0],G[3:0],B[3:0]}
- busy_o  output  1  high in WAIT_FRAME and CAPTURE
- frame_done_o  output  1  one-cycle pulse at end of a captured frame
- error_o  output  1  sticky framing error; cleared by reset or accepted start_i

## Operation
- Synchronizer: pclk, vsync, href and data each pass through 2 flops (s1, s2). A third flop on pclk/vsync/href supports edge detection. pclk_rise = s2 & ~s3. Byte sampled = data s2 on the pclk_rise cycle.
- States:
  - IDLE: start_i -> WAIT_FRAME, clear error_o.
  - WAIT_FRAME: vsync falling edge (synced) -> CAPTURE; clear col, line, address and byte phase.
  - CAPTURE: vsync rising edge -> end of frame (see below).
  - start_i is ignored outside IDLE.
- CAPTURE byte handling, on pclk_rise with href s2 = 1:
  - phase 0: store byte as hi, set phase 1.
  - phase 1: form pixel from {hi, lo}, set phase 0.
- Pixel format: wr_data_o = {hi[7:4], hi[2:0], lo[7], lo[4:1]}, i.e. the top 4 bits of R5, G6 and B5.
- Write gating: a pixel is written only when col < H_PIXELS and line < V_LINES.
  - Written pixel: drive wr_en_o = 1 with the current address, then increment the address.
  - col increments for every completed pixel, written or not.
  - Excess pixels and lines are dropped, never wrapped. The address never exceeds H_PIXELS*V_LINES-1.
- href falling edge in CAPTURE: if col != H_PIXELS, set error_o. Then line++, col = 0, phase = 0. A dangling hi byte is discarded.
- vsync rising edge in CAPTURE:
  - If line != V_LINES, set error_o.
  - Pulse frame_done_o.
  - Next state: continuous_i = 1 -> WAIT_FRAME, else IDLE.
- vsync falling edge seen while already in CAPTURE (glitch/restart): restart the frame with counters cleared, set error_o, no frame_done_o.
- Counter widths: col 9 bits minimum, line 8 bits minimum. Both saturate at their maximum rather than wrap.

## Timing
- Reset values: wr_en_o 0, wr_address_o 0, wr_data_o 0, busy_o 0, frame_done_o 0, error_o 0. State IDLE, all synchronizer flops 0.
- Reset is asynchronous and may occur mid-capture. Outputs clear immediately and no partial write is issued afterward.
- Write latency: a pclk rise at the pin completing a pixel produces wr_en_o = 1 exactly 3 clk_i cycles later. wr_data_o and wr_address_o are valid in the same cycle and are all registered.
- wr_en_o is never high for two consecutive cycles.
- frame_done_o is registered and asserts 3 cycles after the pin vsync rise. wr_address_o then holds the final address value until the next frame start.
- busy_o follows state with 1 cycle register latency.
- Constraint: clk_i frequency >= 4x pclk frequency. Camera signals are stable across the pclk rise.

## Test plan
- Reset then start_i, continuous_i = 0; send a 320x240 frame (vsync fall, 240 href lines of 640 bytes, vsync rise) -> 76800 writes at addresses 0..76799, one frame_done_o pulse, error_o = 0, return to IDLE with busy_o = 0.
- Bytes hi = 0xF8, lo = 0x1F -> wr_data_o = 0xF0F. Bytes hi = 0x07, lo = 0xE0 -> wr_data_o = 0x0F0. Check the 3-cycle latency from the pin pclk rise.
- Line of 642 bytes (321 pixels) -> 320 writes for that line, error_o = 1 at href fall, address continues at line*320.
- continuous_i = 1, two back-to-back frames -> two frame_done_o pulses, second frame restarts at address 0, busy_o stays 1.
- start_i asserted mid-frame (vsync low) -> wait for next vsync fall before any write. Extra start_i pulses during CAPTURE are ignored.
- reset_i asserted at pixel 1000 -> outputs 0 within the same cycle, no wr_en_o until a new start_i and vsync fall.
